// File: rtl/hdmi_timing_gen_if.sv
// Pixel request/return channel between the timing generator and its pixel source.
// The generator issues req_* and the source answers on pix_data one cycle later.
interface hdmi_timing_gen_if #(
  parameter int CNT_W = 12
);
  logic             req_valid;
  logic [CNT_W-1:0] req_x;
  logic [CNT_W-1:0] req_y;
  logic [23:0]      pix_data;

  modport master (
    output req_valid,
    output req_x,
    output req_y,
    input  pix_data
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  req_y,
    output pix_data
  );
endinterface

// File: rtl/hdmi_timing_gen.sv
// Video raster timing generator: h/v counters, 2-stage pixel request/return pipeline, run/stop FSM.
// Optional colour-bar generator enabled by defining HDMI_TEST_PATTERN_EN (adds input tp_en).
module hdmi_timing_gen #(
  parameter int CNT_W      = 12,
  parameter int H_TOTAL    = 2200,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int H_FP       = 88,
  parameter int V_TOTAL    = 1125,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int V_FP       = 4,
  parameter int H_SYNC_POL = 1,
  parameter int V_SYNC_POL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
`ifdef HDMI_TEST_PATTERN_EN
  input  logic             tp_en,
`endif
  hdmi_timing_gen_if.master pix,
  output logic [23:0]      data,
  output logic             h_sync,
  output logic             v_sync,
  output logic             data_en,
  output logic             frame_start,
  output logic             busy,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_TOTAL - H_FP - 1);
  localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_TOTAL - V_FP - 1);
  localparam logic             HS_ACT    = (H_SYNC_POL != 0);
  localparam logic             VS_ACT    = (V_SYNC_POL != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;

  logic             counting;
  logic             h_last;
  logic             v_last;
  logic             hs_raw;
  logic             vs_raw;
  logic             fs_raw;
  logic             act;

  // Stage 1: decoded raster position, also the request to the pixel source
  logic             s1_hs_q, s1_hs_d;
  logic             s1_vs_q, s1_vs_d;
  logic             s1_fs_q, s1_fs_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] req_x_q, req_x_d;
  logic [CNT_W-1:0] req_y_q, req_y_d;

  // Stage 2: aligned with the pixel returned by the source
  logic             h_sync_q, h_sync_d;
  logic             v_sync_q, v_sync_d;
  logic             data_en_q, data_en_d;
  logic             frame_start_q, frame_start_d;

  assign counting = (state_q != IDLE);
  assign h_last   = (hc_q == H_LAST);
  assign v_last   = (vc_q == V_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (run) state_d = RUN;
      RUN:      if (!run) state_d = STOPPING;
      STOPPING: begin
        if (run) begin
          state_d = RUN;
        end else if (h_last && v_last) begin
          state_d = IDLE;
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (!counting) begin
      hc_d = '0;
      vc_d = '0;
    end else if (h_last) begin
      hc_d = '0;
      vc_d = v_last ? '0 : vc_q + ONE;
    end else begin
      hc_d = hc_q + ONE;
    end
  end

  // Everything decoded from the counters is forced inactive while idle, so the pipeline drains.
  always_comb begin
    hs_raw = counting && (hc_q < H_SYNC_C);
    vs_raw = counting && (vc_q < V_SYNC_C);
    fs_raw = counting && (hc_q == '0) && (vc_q == '0);
    act    = counting
          && (hc_q >= H_START_C) && (hc_q <= H_END_C)
          && (vc_q >= V_START_C) && (vc_q <= V_END_C);
  end

  always_comb begin
    s1_hs_d     = hs_raw;
    s1_vs_d     = vs_raw;
    s1_fs_d     = fs_raw;
    req_valid_d = act;
    req_x_d     = act ? (hc_q - H_START_C) : '0;
    req_y_d     = act ? (vc_q - V_START_C) : '0;

    h_sync_d      = s1_hs_q ? HS_ACT : ~HS_ACT;
    v_sync_d      = s1_vs_q ? VS_ACT : ~VS_ACT;
    data_en_d     = req_valid_q;
    frame_start_d = s1_fs_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hc_q          <= '0;
      vc_q          <= '0;
      s1_hs_q       <= 1'b0;
      s1_vs_q       <= 1'b0;
      s1_fs_q       <= 1'b0;
      req_valid_q   <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      h_sync_q      <= ~HS_ACT;
      v_sync_q      <= ~VS_ACT;
      data_en_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      s1_hs_q       <= s1_hs_d;
      s1_vs_q       <= s1_vs_d;
      s1_fs_q       <= s1_fs_d;
      req_valid_q   <= req_valid_d;
      req_x_q       <= req_x_d;
      req_y_q       <= req_y_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      data_en_q     <= data_en_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef HDMI_TEST_PATTERN_EN
  localparam int H_ACTIVE = H_TOTAL - H_SYNC - H_BP - H_FP;
  localparam int BAR_W    = ((H_ACTIVE >> 3) > 0) ? (H_ACTIVE >> 3) : 1;
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    logic [23:0] rgb;
    unique case (idx)
      3'd0:    rgb = 24'hFFFFFF;
      3'd1:    rgb = 24'hFFFF00;
      3'd2:    rgb = 24'h00FFFF;
      3'd3:    rgb = 24'h00FF00;
      3'd4:    rgb = 24'hFF00FF;
      3'd5:    rgb = 24'hFF0000;
      3'd6:    rgb = 24'h0000FF;
      default: rgb = 24'h000000;
    endcase
    return rgb;
  endfunction

  logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  logic [2:0]       s1_bar_q, s1_bar_d;
  logic [2:0]       s2_bar_q, s2_bar_d;
  logic             bar_first;
  logic [CNT_W-1:0] cur_cnt;
  logic [2:0]       cur_idx;

  // The first active pixel of a line restarts the bar walk regardless of leftover state.
  always_comb begin
    bar_first = (hc_q == H_START_C);
    cur_cnt   = bar_first ? '0 : bar_cnt_q;
    cur_idx   = bar_first ? 3'd0 : bar_idx_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    if (act) begin
      if (cur_cnt == BAR_LAST) begin
        bar_cnt_d = '0;
        bar_idx_d = (cur_idx == 3'd7) ? 3'd7 : cur_idx + 3'd1;
      end else begin
        bar_cnt_d = cur_cnt + ONE;
        bar_idx_d = cur_idx;
      end
    end
    s1_bar_d = act ? cur_idx : 3'd0;
    s2_bar_d = s1_bar_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bar_cnt_q <= '0;
      bar_idx_q <= 3'd0;
      s1_bar_q  <= 3'd0;
      s2_bar_q  <= 3'd0;
    end else begin
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      s1_bar_q  <= s1_bar_d;
      s2_bar_q  <= s2_bar_d;
    end
  end

  assign data = data_en_q ? (tp_en ? bar_rgb(s2_bar_q) : pix.pix_data) : 24'h0;
`else
  // pix_data arrives in the same cycle as data_en, so it passes through combinationally.
  assign data = data_en_q ? pix.pix_data : 24'h0;
`endif

  assign pix.req_valid = req_valid_q;
  assign pix.req_x     = req_x_q;
  assign pix.req_y     = req_y_q;
  assign h_sync        = h_sync_q;
  assign v_sync        = v_sync_q;
  assign data_en       = data_en_q;
  assign frame_start   = frame_start_q;
  assign busy          = counting;
  assign clk_out       = ~clk;

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Directed bench for hdmi_timing_gen on the small 16x8 raster, with a second instance at
// inverted sync polarity and (when HDMI_TEST_PATTERN_EN is defined) a 23-pixel colour-bar instance.
module tb_hdmi_timing_gen;

  localparam int CW = 8;

  logic clk;
  logic rst;
  logic run;

  int n_checks;
  int n_err;

  hdmi_timing_gen_if #(.CNT_W(CW)) pif ();
  hdmi_timing_gen_if #(.CNT_W(CW)) pif_p ();

  logic [23:0] data, data_p;
  logic h_sync, v_sync, data_en, frame_start, busy, clk_out;
  logic h_sync_p, v_sync_p, data_en_p, frame_start_p, busy_p, clk_out_p;

  hdmi_timing_gen #(
    .CNT_W(CW), .H_TOTAL(16), .H_SYNC(2), .H_BP(3), .H_FP(2),
    .V_TOTAL(8), .V_SYNC(1), .V_BP(1), .V_FP(1), .H_SYNC_POL(1), .V_SYNC_POL(1)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef HDMI_TEST_PATTERN_EN
    .tp_en(1'b0),
`endif
    .pix(pif), .data(data), .h_sync(h_sync), .v_sync(v_sync), .data_en(data_en),
    .frame_start(frame_start), .busy(busy), .clk_out(clk_out)
  );

  hdmi_timing_gen #(
    .CNT_W(CW), .H_TOTAL(16), .H_SYNC(2), .H_BP(3), .H_FP(2),
    .V_TOTAL(8), .V_SYNC(1), .V_BP(1), .V_FP(1), .H_SYNC_POL(0), .V_SYNC_POL(0)
  ) dut_p (
    .clk(clk), .rst(rst), .run(run),
`ifdef HDMI_TEST_PATTERN_EN
    .tp_en(1'b0),
`endif
    .pix(pif_p), .data(data_p), .h_sync(h_sync_p), .v_sync(v_sync_p), .data_en(data_en_p),
    .frame_start(frame_start_p), .busy(busy_p), .clk_out(clk_out_p)
  );

`ifdef HDMI_TEST_PATTERN_EN
  hdmi_timing_gen_if #(.CNT_W(CW)) pif_t ();
  logic [23:0] data_t;
  logic h_sync_t, v_sync_t, data_en_t, frame_start_t, busy_t, clk_out_t;

  hdmi_timing_gen #(
    .CNT_W(CW), .H_TOTAL(23), .H_SYNC(2), .H_BP(3), .H_FP(2),
    .V_TOTAL(8), .V_SYNC(1), .V_BP(1), .V_FP(1), .H_SYNC_POL(1), .V_SYNC_POL(1)
  ) dut_t (
    .clk(clk), .rst(rst), .run(run), .tp_en(1'b1),
    .pix(pif_t), .data(data_t), .h_sync(h_sync_t), .v_sync(v_sync_t), .data_en(data_en_t),
    .frame_start(frame_start_t), .busy(busy_t), .clk_out(clk_out_t)
  );

  initial pif_t.pix_data = 24'h123456;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel source: registered loopback of the request coordinates.
  always @(posedge clk) pif.pix_data <= {8'h00, pif.req_y, pif.req_x};
  initial pif_p.pix_data = 24'h0;

  typedef struct {
    logic rst;
    logic run;
    logic busy;
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic rv;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_fs(input string name);
    int k;
    k = 0;
    while (frame_start !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    check({name, "_fs_found"}, 32'(frame_start), 32'd1);
  endtask

  initial begin
    int n_de, first_de, last_de, n_rv, run_len, lines9;
    int bad_data, bad_rv, bad_req, bad_zero, bad_idle, bad_busy;
    int hs_cnt, vs_cnt, fs_cnt, hs_p_low, vs_p_low;
    logic prev_rv;
    logic [23:0] first_data, last_data;

    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    run      = 1'b0;

    //            rst   run   busy  hs    vs    de    fs    rv
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      rst = vecs[i].rst;
      run = vecs[i].run;
      tick();
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_hsync", i), 32'(h_sync), 32'(vecs[i].hs));
      check($sformatf("vec%0d_vsync", i), 32'(v_sync), 32'(vecs[i].vs));
      check($sformatf("vec%0d_de", i), 32'(data_en), 32'(vecs[i].de));
      check($sformatf("vec%0d_fs", i), 32'(frame_start), 32'(vecs[i].fs));
      check($sformatf("vec%0d_rv", i), 32'(pif.req_valid), 32'(vecs[i].rv));
      if (i < 2) begin
        check($sformatf("vec%0d_data", i), 32'(data), 32'd0);
        check($sformatf("vec%0d_hsync_p", i), 32'(h_sync_p), 32'd1);
        check($sformatf("vec%0d_vsync_p", i), 32'(v_sync_p), 32'd1);
      end
    end
    $display("vectors done: checks=%0d errors=%0d", n_checks, n_err);

    // Full raster frame with loopback data
    wait_fs("raster");
    n_de = 0; first_de = -1; last_de = -1; n_rv = 0; run_len = 0; lines9 = 0;
    bad_data = 0; bad_rv = 0; bad_req = 0; bad_zero = 0;
    hs_cnt = 0; vs_cnt = 0; fs_cnt = 0; hs_p_low = 0; vs_p_low = 0;
    prev_rv = 1'b0; first_data = 24'hx; last_data = 24'hx;
    for (int t = 0; t < 128; t++) begin
      if (data_en === 1'b1) begin
        if (data !== {8'h00, 8'(n_de / 9), 8'(n_de % 9)}) bad_data++;
        if (first_de < 0) begin
          first_de   = t;
          first_data = data;
        end
        last_de   = t;
        last_data = data;
        n_de++;
        run_len++;
      end else begin
        if (run_len == 9) lines9++;
        run_len = 0;
      end
      if (t > 0 && data_en !== prev_rv) bad_rv++;
      prev_rv = pif.req_valid;
      if (pif.req_valid === 1'b1) begin
        if (pif.req_x !== 8'(n_rv % 9) || pif.req_y !== 8'(n_rv / 9)) bad_req++;
        n_rv++;
      end else if (pif.req_x !== 8'd0 || pif.req_y !== 8'd0) begin
        bad_zero++;
      end
      if (h_sync === 1'b1) hs_cnt++;
      if (v_sync === 1'b1) vs_cnt++;
      if (frame_start === 1'b1) fs_cnt++;
      if (h_sync_p === 1'b0) hs_p_low++;
      if (v_sync_p === 1'b0) vs_p_low++;
      tick();
    end
    check("raster_de_count", 32'(n_de), 32'd45);
    check("raster_lines_of_9", 32'(lines9), 32'd5);
    check("raster_first_de_t", 32'(first_de), 32'd37);
    check("raster_last_de_t", 32'(last_de), 32'd109);
    check("align_first_data", 32'(first_data), 32'h000000);
    check("align_last_data", 32'(last_data), 32'h000408);
    check("align_all_data_bad", 32'(bad_data), 32'd0);
    check("req_leads_de_bad", 32'(bad_rv), 32'd0);
    check("req_xy_bad", 32'(bad_req), 32'd0);
    check("req_xy_zero_bad", 32'(bad_zero), 32'd0);
    check("hsync_high_count", 32'(hs_cnt), 32'd16);
    check("vsync_high_count", 32'(vs_cnt), 32'd16);
    check("fs_count_in_frame", 32'(fs_cnt), 32'd1);
    check("fs_period_128", 32'(frame_start), 32'd1);
    check("pol_hsync_low_count", 32'(hs_p_low), 32'd16);
    check("pol_vsync_low_count", 32'(vs_p_low), 32'd16);

    // Stop request at vc=3: frame completes, then idle
    wait_fs("stop");
    n_de = 0; bad_idle = 0;
    for (int t = 0; t <= 140; t++) begin
      if (t < 128 && data_en === 1'b1) n_de++;
      if (t == 125) check("stop_busy_before_end", 32'(busy), 32'd1);
      if (t == 126) check("stop_busy_after_end", 32'(busy), 32'd0);
      if (t >= 128) begin
        if (data_en !== 1'b0 || h_sync !== 1'b0 || v_sync !== 1'b0 || frame_start !== 1'b0
            || pif.req_valid !== 1'b0 || data !== 24'h0 || busy !== 1'b0) bad_idle++;
      end
      if (t == 50) run = 1'b0;
      if (t < 140) tick();
    end
    check("stop_de_count", 32'(n_de), 32'd45);
    check("stop_idle_outputs_bad", 32'(bad_idle), 32'd0);
    check("stop_pol_hsync_idle", 32'(h_sync_p), 32'd1);
    check("stop_pol_vsync_idle", 32'(v_sync_p), 32'd1);
    run = 1'b1;
    tick();
    check("restart_busy", 32'(busy), 32'd1);
    tick();
    check("restart_fs_early", 32'(frame_start), 32'd0);
    tick();
    check("restart_fs", 32'(frame_start), 32'd1);

    // Brief stop then resume mid-frame: frame continues uninterrupted
    n_de = 0; bad_busy = 0;
    for (int t = 0; t < 128; t++) begin
      if (data_en === 1'b1) n_de++;
      if (busy !== 1'b1) bad_busy++;
      if (t == 20) run = 1'b0;
      if (t == 30) run = 1'b1;
      tick();
    end
    check("resume_de_count", 32'(n_de), 32'd45);
    check("resume_busy_bad", 32'(bad_busy), 32'd0);
    check("resume_fs_period", 32'(frame_start), 32'd1);

    // Reset at vc=4, hc=7 (counter leads stage-2 by two cycles)
    for (int t = 0; t < 69; t++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid_data", 32'(data), 32'd0);
    check("rst_mid_de", 32'(data_en), 32'd0);
    check("rst_mid_rv", 32'(pif.req_valid), 32'd0);
    check("rst_mid_req_x", 32'(pif.req_x), 32'd0);
    check("rst_mid_req_y", 32'(pif.req_y), 32'd0);
    check("rst_mid_fs", 32'(frame_start), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_hsync", 32'(h_sync), 32'd0);
    check("rst_mid_vsync", 32'(v_sync), 32'd0);
    check("rst_mid_hsync_p", 32'(h_sync_p), 32'd1);
    check("rst_mid_vsync_p", 32'(v_sync_p), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("rst_hold%0d_de", k), 32'(data_en), 32'd0);
      check($sformatf("rst_hold%0d_busy", k), 32'(busy), 32'd0);
    end
    rst = 1'b0;
    tick();
    check("rst_release_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("rst_release_fs", 32'(frame_start), 32'd1);

`ifdef HDMI_TEST_PATTERN_EN
    begin
      logic [23:0] bars[8];
      int k, pos, n_de_t, bad_col;
      bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
      bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
      k = 0;
      while (frame_start_t !== 1'b1 && k < 400) begin
        tick();
        k++;
      end
      check("tp_fs_found", 32'(frame_start_t), 32'd1);
      pos = 0; n_de_t = 0; bad_col = 0;
      for (int t = 0; t < 184; t++) begin
        if (data_en_t === 1'b1) begin
          if (data_t !== bars[(pos / 2 > 7) ? 7 : pos / 2]) bad_col++;
          pos++;
          n_de_t++;
        end else begin
          pos = 0;
        end
        tick();
      end
      check("tp_de_count", 32'(n_de_t), 32'd80);
      check("tp_colour_bad", 32'(bad_col), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
